ctrl_seq: RTL
=============

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have parameter NHEX, default 1 (range 1..8): number of HEX output channels, mapped to CSR addresses 12'hF02 through 12'hF02+NHEX-1.
REQ-002 The block SHALL have parameter MUL_LAT, default 2 (range 1..15): number of wait cycles the block holds a multiply op before presenting it.
REQ-003 The block SHALL have these ports:
  clk  in  1  sole clock; all logic rising-edge.
  rst  in  1  synchronous, active-high reset.
  in_valid  in  1  instruction fields valid.
  in_ready  out  1  block accepts fields this cycle.
  opcode  in  7  instruction opcode.
  funct3  in  3  instruction funct3.
  funct7  in  7  instruction funct7.
  csr  in  12  CSR address field.
  out_valid  out  1  registered control word valid.
  out_ready  in  1  downstream consumes control word.
  aluop  out  4  ALU operation.
  regsel  out  2  writeback select: 00 IO/CSR, 01 U-immediate, 10 ALU.
  alusrc  out  1  1 selects immediate operand.
  regwe  out  1  register-file write enable.
  hexwe  out  NHEX  one-hot HEX channel write enable.
  illegal  out  1  undecodable instruction flag.

Function
REQ-004 The aluop encodings SHALL be: and 0000, or 0001, xor 0010, add 0011, sub 0100, mul 0101, mulh 0110, mulhu 0111, sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101.
REQ-005 Decode SHALL produce the following control words:
  R-type (7'h33): regwe=1, regsel=10, alusrc=0; aluop from funct3/funct7.
  I-type (7'h13): regwe=1, regsel=10, alusrc=1; funct7 checked only for shifts.
  LUI (7'h37): regwe=1, regsel=01, alusrc=1, aluop=0000.
  CSRRW (7'h73, funct3=001): regsel=00; if csr=F02+k with k<NHEX, hexwe[k]=1 and regwe=0; otherwise regwe=1.
REQ-006 The block SHALL have three states, IDLE, HOLD and MULWAIT, with these transitions:
  IDLE to HOLD on accept of a non-multiply instruction.
  IDLE to MULWAIT on accept of mul, mulh or mulhu.
  MULWAIT to HOLD after MUL_LAT cycles.
  HOLD to IDLE on out_ready with no new accept.
REQ-007 in_ready SHALL be 1 in IDLE, equal out_ready in HOLD, and be 0 in MULWAIT.
REQ-008 An accept (in_valid and in_ready) SHALL register the decoded word; out_valid SHALL rise the next cycle for non-multiply ops, or exactly MUL_LAT+1 cycles after accept for multiply ops.
REQ-009 When in HOLD and out_ready and in_valid are high in the same cycle, the block SHALL retire the current word and accept the new one (back-to-back, zero bubbles); the next state is HOLD, or MULWAIT for a multiply op.
REQ-010 While out_valid=1 and out_ready=0, all control outputs SHALL hold stable.
REQ-011 regwe and hexwe SHALL be forced to 0 whenever out_valid=0; aluop, regsel and alusrc SHALL hold their last value.
REQ-012 The MULWAIT counter SHALL be 4 bits wide, load MUL_LAT-1, count down to 0, and never wrap.
REQ-013 Unknown opcodes SHALL produce a no-op word (regwe=0, hexwe=0) that still completes the handshake.

Reset
REQ-014 When rst=1 the block SHALL enter IDLE and set out_valid=0, aluop=0000, regsel=01, alusrc=0, regwe=0, hexwe=0, illegal=0 and counter=0.
REQ-015 Reset during MULWAIT or HOLD SHALL discard the in-flight word; no write enable SHALL be asserted in the cycle after reset deasserts.
REQ-016 in_ready SHALL be 0 while rst=1.

Configuration
REQ-017 With macro CTRL_ILLEGAL_EN defined, illegal SHALL be 1 with out_valid for an unknown opcode, an unknown R-type funct3/funct7 combination, or a CSRRW to an unmapped CSR above F02+NHEX-1 within 12'hF00-12'hFFF; the illegal word SHALL carry regwe=0 and hexwe=0.
REQ-018 Without CTRL_ILLEGAL_EN, illegal SHALL be tied to 0, and an unknown R-type combination SHALL decode as mulhu (aluop 0111, regwe=1).

Structure
REQ-019 Package ctrl_pkg SHALL hold the aluop enum, the regsel constants, the opcode constants (OP_R, OP_I, OP_LUI, OP_SYS), the HEX base CSR constant 12'hF02, and the state enum.
REQ-020 Decode SHALL be a combinational sub-module, ctrl_decode, parametrised by NHEX; ctrl_seq SHALL own the state machine, the counter and the output registers.

Verification
REQ-021 A bench SHALL cover these directed scenarios:
  rst then add (33/000/00), out_ready=1: out_valid at cycle+1, aluop=0011, regsel=10, regwe=1.
  mul (33/000/01), MUL_LAT=3: in_ready=0 for 3 cycles; out_valid at cycle+4 with aluop=0101.
  CSRRW csr=F03, NHEX=2: hexwe=2'b10, regwe=0; csr=F00: regwe=1, regsel=00, hexwe=0.
  out_ready=0 for 5 cycles with in_valid held: outputs stable, in_ready=0; out_ready=1 then retires the word and accepts the next back-to-back.
  rst asserted during MULWAIT: next cycle out_valid=0, regwe=0, state IDLE.
  opcode 7'h7F: illegal=1 with CTRL_ILLEGAL_EN, 0 without; regwe=0 in both builds.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer.
// Optional feature macro: CTRL_ILLEGAL_EN (enables illegal-instruction flagging).
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_ADD   = 4'b0011,
    ALU_SUB   = 4'b0100,
    ALU_MUL   = 4'b0101,
    ALU_MULH  = 4'b0110,
    ALU_MULHU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101
  } aluop_t;

  localparam logic [1:0] REGSEL_IO   = 2'b00;
  localparam logic [1:0] REGSEL_UIMM = 2'b01;
  localparam logic [1:0] REGSEL_ALU  = 2'b10;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_SYS = 7'h73;

  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic [11:0] HEX_BASE = 12'hF02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_MULWAIT
  } state_t;

`ifdef CTRL_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  // Multiply-class ops are the ones that need the extra MULWAIT hold time.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder producing one control word.
// Optional feature macro: CTRL_ILLEGAL_EN (via ctrl_pkg::ILLEGAL_EN).
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int NHEX = 1
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [11:0]     csr,
  output logic [3:0]      aluop,
  output logic [1:0]      regsel,
  output logic            alusrc,
  output logic            regwe,
  output logic [NHEX-1:0] hexwe,
  output logic            illegal,
  output logic            is_mul
);

  logic [NHEX-1:0] hex_sel;
  logic            hex_hit;
  logic            csr_unmapped;
  logic            r_known;
  aluop_t          r_op;
  aluop_t          i_op;

  // One comparator per HEX channel; at most one can match.
  generate
    for (genvar gi = 0; gi < NHEX; gi++) begin : g_hex
      assign hex_sel[gi] = (csr == HEX_BASE + 12'(gi));
    end
  endgenerate

  assign hex_hit      = |hex_sel;
  assign csr_unmapped = (csr[11:8] == 4'hF) && (csr >= HEX_BASE + 12'(NHEX));

  // R-type op from {funct7, funct3}; unmatched combos fall back to mulhu.
  always_comb begin
    r_op    = ALU_MULHU;
    r_known = 1'b1;
    case ({funct7, funct3})
      {7'h00, 3'b000}: r_op = ALU_ADD;
      {7'h20, 3'b000}: r_op = ALU_SUB;
      {7'h01, 3'b000}: r_op = ALU_MUL;
      {7'h00, 3'b001}: r_op = ALU_SLL;
      {7'h01, 3'b001}: r_op = ALU_MULH;
      {7'h00, 3'b010}: r_op = ALU_SLT;
      {7'h00, 3'b011}: r_op = ALU_SLTU;
      {7'h01, 3'b011}: r_op = ALU_MULHU;
      {7'h00, 3'b100}: r_op = ALU_XOR;
      {7'h00, 3'b101}: r_op = ALU_SRL;
      {7'h20, 3'b101}: r_op = ALU_SRA;
      {7'h00, 3'b110}: r_op = ALU_OR;
      {7'h00, 3'b111}: r_op = ALU_AND;
      default:         r_known = 1'b0;
    endcase
  end

  // I-type op from funct3; funct7 only distinguishes srai from srli.
  always_comb begin
    i_op = ALU_ADD;
    case (funct3)
      3'b000: i_op = ALU_ADD;
      3'b001: i_op = ALU_SLL;
      3'b010: i_op = ALU_SLT;
      3'b011: i_op = ALU_SLTU;
      3'b100: i_op = ALU_XOR;
      3'b101: i_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: i_op = ALU_OR;
      3'b111: i_op = ALU_AND;
    endcase
  end

  // Assemble the control word; anything unrecognised becomes a no-op.
  always_comb begin
    aluop   = ALU_AND;
    regsel  = REGSEL_UIMM;
    alusrc  = 1'b0;
    regwe   = 1'b0;
    hexwe   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        regsel = REGSEL_ALU;
        aluop  = r_op;
        regwe  = 1'b1;
        if (ILLEGAL_EN && !r_known) begin
          aluop   = ALU_AND;
          regwe   = 1'b0;
          illegal = 1'b1;
        end
      end
      OP_I: begin
        regsel = REGSEL_ALU;
        alusrc = 1'b1;
        aluop  = i_op;
        regwe  = 1'b1;
      end
      OP_LUI: begin
        regsel = REGSEL_UIMM;
        alusrc = 1'b1;
        aluop  = ALU_AND;
        regwe  = 1'b1;
      end
      OP_SYS: begin
        if (funct3 == F3_CSRRW) begin
          regsel = REGSEL_IO;
          if (hex_hit) begin
            hexwe = hex_sel;
          end else if (ILLEGAL_EN && csr_unmapped) begin
            illegal = 1'b1;
          end else begin
            regwe = 1'b1;
          end
        end else begin
          illegal = ILLEGAL_EN;
        end
      end
      default: illegal = ILLEGAL_EN;
    endcase
  end

  assign is_mul = is_mul_op(aluop);

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: accepts instruction fields, holds multiply ops for
// MUL_LAT cycles, and presents a registered control word with valid/ready.
// Optional feature macro: CTRL_ILLEGAL_EN (drives the illegal output).
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int NHEX    = 1,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [11:0]     csr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      aluop,
  output logic [1:0]      regsel,
  output logic            alusrc,
  output logic            regwe,
  output logic [NHEX-1:0] hexwe,
  output logic            illegal
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            out_valid_reg;
  logic [3:0]      aluop_reg;
  logic [1:0]      regsel_reg;
  logic            alusrc_reg;
  logic            regwe_reg;
  logic [NHEX-1:0] hexwe_reg;
  logic            illegal_reg;

  logic [3:0]      dec_aluop;
  logic [1:0]      dec_regsel;
  logic            dec_alusrc;
  logic            dec_regwe;
  logic [NHEX-1:0] dec_hexwe;
  logic            dec_illegal;
  logic            dec_is_mul;
  logic            accept;

  ctrl_decode #(.NHEX(NHEX)) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .csr     (csr),
    .aluop   (dec_aluop),
    .regsel  (dec_regsel),
    .alusrc  (dec_alusrc),
    .regwe   (dec_regwe),
    .hexwe   (dec_hexwe),
    .illegal (dec_illegal),
    .is_mul  (dec_is_mul)
  );

  // Ready depends on state; in HOLD a new word may enter only as the old one leaves.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: in_ready = 1'b1;
        ST_HOLD: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // State machine, multiply countdown and control-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      aluop_reg     <= ALU_AND;
      regsel_reg    <= REGSEL_UIMM;
      alusrc_reg    <= 1'b0;
      regwe_reg     <= 1'b0;
      hexwe_reg     <= '0;
      illegal_reg   <= 1'b0;
    end else begin
      if (accept) begin
        aluop_reg   <= dec_aluop;
        regsel_reg  <= dec_regsel;
        alusrc_reg  <= dec_alusrc;
        regwe_reg   <= dec_regwe;
        hexwe_reg   <= dec_hexwe;
        illegal_reg <= dec_illegal;
      end
      case (state_reg)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (dec_is_mul) begin
              state_reg     <= ST_MULWAIT;
              cnt_reg       <= CNT_LOAD;
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= ST_HOLD;
              out_valid_reg <= 1'b1;
            end
          end else if ((state_reg == ST_HOLD) && out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        ST_MULWAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg     <= ST_HOLD;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign aluop     = aluop_reg;
  assign regsel    = regsel_reg;
  assign alusrc    = alusrc_reg;
  // Write enables only ever appear alongside a valid word.
  assign regwe     = out_valid_reg & regwe_reg;
  assign hexwe     = {NHEX{out_valid_reg}} & hexwe_reg;
  assign illegal   = ILLEGAL_EN & out_valid_reg & illegal_reg;

endmodule
